// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with NZCV/err flags and an iterative shift-add multiplier
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           input handshake for op, num1, num2
//   op[3:0], num1, num2         operation code and operands (shift amount = num2[$clog2(WIDTH)-1:0])
//   out_valid/out_ready         output handshake; out and flags held while out_valid && !out_ready
//   out, z, n, c, v, err        registered result, zero/negative/carry-borrow/overflow, illegal-op flag
module alu_seq #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             err
);
  localparam int CW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, w_res, w_sum, w_dif, w_prod;
  logic [CW-1:0] r_cnt, w_amt;
  logic w_take, w_mul, w_last, w_co, w_c, w_v, w_err;
  assign in_ready  = r_state == IDLE || (r_state == DONE && out_ready);
  assign out_valid = r_state == DONE;
  assign w_take    = in_valid && in_ready;
  assign w_mul     = MUL_EN && op == 4'b1101;
  assign w_last    = r_cnt == CW'(WIDTH - 1);
  assign w_amt     = num2[CW-1:0];
  assign {w_co, w_sum} = {1'b0, num1} + {1'b0, num2};
  assign w_dif     = num1 - num2;
  // one shift-add step of the multiplier; the final step's sum is the product
  assign w_prod    = r_acc + (r_b[r_cnt] ? r_a << r_cnt : '0);
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (op)
      4'b0000: w_res = num1 & num2;
      4'b0001: w_res = num1 | num2;
      4'b0010: begin
        w_res = w_sum;
        w_c   = w_co;
        w_v   = num1[M] == num2[M] && w_sum[M] != num1[M];
      end
      4'b0011: w_res = num1 ^ num2;
      4'b0100: w_res = {{(WIDTH-1){1'b0}}, $signed(num1) < $signed(num2)};
      4'b0101: w_res = {{(WIDTH-1){1'b0}}, num1 < num2};
      4'b0110: begin
        w_res = w_dif;
        w_c   = num1 < num2;
        w_v   = num1[M] != num2[M] && w_dif[M] != num1[M];
      end
      4'b0111: w_res = num2;
      4'b1000: w_res = num1 << w_amt;
      4'b1001: w_res = num1 >> w_amt;
      4'b1010: w_res = $signed(num1) >>> w_amt;
      4'b1100: w_res = ~(num1 | num2);
      4'b1101: w_err = !MUL_EN;
      default: w_err = 1'b1;
    endcase
  end
  always_comb begin
    w_next = w_take ? (w_mul ? BUSY : DONE) :
             r_state == BUSY ? (w_last ? DONE : BUSY) :
             r_state == DONE && !out_ready ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      out   <= '0;
      z     <= 1'b0;
      n     <= 1'b0;
      c     <= 1'b0;
      v     <= 1'b0;
      err   <= 1'b0;
    end else if (w_take && w_mul) begin
      r_a   <= num1;
      r_b   <= num2;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      out <= w_res;
      z   <= w_res == '0;
      n   <= w_res[M];
      c   <= w_c;
      v   <= w_v;
      err <= w_err;
    end else if (r_state == BUSY) begin
      r_acc <= w_prod;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        out <= w_prod;
        z   <= w_prod == '0;
        n   <= w_prod[M];
        c   <= 1'b0;
        v   <= 1'b0;
        err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8) with an integer reference model
module tb_alu_seq;
  localparam int W = 8;
  typedef struct packed {
    logic [W-1:0] out;
    logic z, n, c, v, err;
  } res_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, e_valid = 1'b0, e_oready = 1'b1;
  logic [3:0] op = '0;
  logic [W-1:0] num1 = '0, num2 = '0, out, eout;
  logic in_ready, out_valid, z, n, c, v, err;
  logic e_ready, e_ovalid, ez, en, ec, ev, eerr;
  res_t q[$];
  int hs[$];
  int checks = 0, passed = 0, cyc = 0;
  bit rnd = 1'b0;
  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .num1(num1), .num2(num2), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .z(z), .n(n), .c(c), .v(v), .err(err));
  alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(e_valid), .in_ready(e_ready), .op(op),
    .num1(num1), .num2(num2), .out_valid(e_ovalid), .out_ready(e_oready), .out(eout),
    .z(ez), .n(en), .c(ec), .v(ev), .err(eerr));
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  function automatic res_t model(input logic [3:0] o, input logic [W-1:0] a8, input logic [W-1:0] b8);
    int a, b, sa, sb, r, amt;
    res_t x;
    x = '0;
    a = int'(a8);
    b = int'(b8);
    sa = a >= 2**(W-1) ? a - 2**W : a;
    sb = b >= 2**(W-1) ? b - 2**W : b;
    amt = b % W;
    r = 0;
    case (o)
      0: r = a & b;
      1: r = a | b;
      2: begin
        r = a + b;
        x.c = r >= 2**W;
        x.v = sa + sb > 2**(W-1) - 1 || sa + sb < -(2**(W-1));
      end
      3: r = a ^ b;
      4: r = int'(sa < sb);
      5: r = int'(a < b);
      6: begin
        r = a - b;
        x.c = a < b;
        x.v = sa - sb > 2**(W-1) - 1 || sa - sb < -(2**(W-1));
      end
      7: r = b;
      8: r = a << amt;
      9: r = a >> amt;
      10: r = sa >>> amt;
      12: r = ~(a | b);
      13: r = a * b;
      default: x.err = 1'b1;
    endcase
    x.out = W'(r);
    x.z = x.out == '0;
    x.n = x.out[W-1];
    return x;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got=%h expected=%h", nm, got, exp);
  endtask
  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    op = o;
    num1 = a;
    num2 = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd) out_ready = $urandom_range(0, 3) != 0;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q.push_back(model(o, a, b));
    #1;
    in_valid = 1'b0;
    if (rnd) out_ready = $urandom_range(0, 3) != 0;
  endtask
  initial begin
    bit stalled;
    res_t held, exp;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (stalled) chk("stall_hold", {out_valid, out, z, n, c, v, err}, {1'b1, held});
      if (rst_n && out_valid && out_ready) begin
        hs.push_back(cyc);
        if (q.size() == 0) chk("unexpected_output", {out, z, n, c, v, err}, 0);
        else begin
          exp = q.pop_front();
          chk("result", {out, z, n, c, v, err}, exp);
        end
      end
      stalled = rst_n && out_valid && !out_ready;
      held = {out, z, n, c, v, err};
    end
  end
  initial begin
    int busy, d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {out_valid, out, z, n, c, v, err}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {in_ready, out_valid}, 2'b10);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'd2, 8'hFF, 8'h01);
    send(4'd6, 8'h80, 8'h01);
    send(4'd6, 8'h01, 8'h02);
    send(4'd10, 8'h90, 8'h0B);
    send(4'd4, 8'hFF, 8'h01);
    send(4'd5, 8'hFF, 8'h01);
    send(4'd13, 8'd13, 8'd11);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      chk("mul_busy_in_ready", in_ready, 0);
      busy++;
    end
    chk("mul_latency", busy, 8);
    @(posedge clk);
    #1;
    op = 4'd13;
    num1 = 8'd13;
    num2 = 8'd11;
    e_valid = 1'b1;
    @(negedge clk);
    chk("nomul_ready", e_ready, 1);
    @(posedge clk);
    #1;
    e_valid = 1'b0;
    @(negedge clk);
    chk("nomul_illegal", {e_ovalid, eout, ez, en, ec, ev, eerr}, {1'b1, 8'h00, 5'b10001});
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(4'd2, 8'd2, 8'd3);
    op = 4'd2;
    num1 = 8'd7;
    num2 = 8'd9;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out", {out_valid, out}, {1'b1, 8'd5});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    fork
      send(4'd2, 8'd7, 8'd9);
      begin
        @(negedge clk);
        chk("same_cycle_accept", {in_ready, out_valid}, 2'b11);
      end
    join
    send(4'd2, 8'd10, 8'd20);
    send(4'd2, 8'd100, 8'd100);
    send(4'd2, 8'd127, 8'd1);
    send(4'd2, 8'd200, 8'd56);
    @(negedge clk);
    d = hs.size() >= 4 ? hs[hs.size()-1] - hs[hs.size()-4] : -1;
    chk("back_to_back", d, 3);
    @(posedge clk);
    #1;
    send(4'd13, 8'd5, 8'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_mul", {out_valid, out, z, n, c, v, err}, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", {in_ready, out_valid}, 2'b10);
    @(posedge clk);
    #1;
    send(4'd2, 8'd1, 8'd1);
    rnd = 1'b1;
    repeat (300) send(4'($urandom), W'($urandom), W'($urandom));
    rnd = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
